// File: rtl/bcd_timer.sv
// MM:SS BCD run/pause/clear/load timer stepped by a synchronised divided clock.
// Counts up with wrap at 59:59 or down to 00:00, where it stops in DONE.
module bcd_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_d,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic       dir,
    input  logic [3:0] ld_mt,
    input  logic [3:0] ld_mo,
    input  logic [3:0] ld_st,
    input  logic [3:0] ld_so,
    output logic [3:0] mt,
    output logic [3:0] mo,
    output logic [3:0] st,
    output logic [3:0] so,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t     state, state_n;
    logic       s1, s2, s3, v1, v2, armed, tick;
    logic [3:0] mt_n, mo_n, st_n, so_n;
    logic [3:0] u_mt, u_mo, u_st, u_so;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic       at_le1;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // armed needs one genuine low sample after reset, so a clk_d already high
    // at reset release cannot produce a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= clk_d;
            s2    <= s1;
            s3    <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            armed <= armed | (v2 & ~s2);
        end
    end

    assign tick   = s2 & ~s3 & armed;
    assign at_le1 = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so <= 4'd1);

    always_comb begin
        u_mt = mt;
        u_mo = mo;
        u_st = st;
        u_so = so + 4'd1;
        if (so == 4'd9) begin
            u_so = 4'd0;
            u_st = st + 4'd1;
            if (st == 4'd5) begin
                u_st = 4'd0;
                u_mo = mo + 4'd1;
                if (mo == 4'd9) begin
                    u_mo = 4'd0;
                    u_mt = (mt == 4'd5) ? 4'd0 : mt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        d_mt = mt;
        d_mo = mo;
        d_st = st;
        d_so = so - 4'd1;
        if (so == 4'd0) begin
            d_so = 4'd9;
            d_st = st - 4'd1;
            if (st == 4'd0) begin
                d_st = 4'd5;
                d_mo = mo - 4'd1;
                if (mo == 4'd0) begin
                    d_mo = 4'd9;
                    d_mt = mt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        mt_n    = mt;
        mo_n    = mo;
        st_n    = st;
        so_n    = so;
        if (clear) begin
            state_n = IDLE;
            {mt_n, mo_n, st_n, so_n} = 16'h0000;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (load) begin
                        mt_n = clamp(ld_mt, 4'd5);
                        mo_n = clamp(ld_mo, 4'd9);
                        st_n = clamp(ld_st, 4'd5);
                        so_n = clamp(ld_so, 4'd9);
                    end else if (start) begin
                        if (state == IDLE && dir && at_le1 && so == 4'd0)
                            state_n = DONE;
                        else
                            state_n = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (!dir) begin
                            {mt_n, mo_n, st_n, so_n} = {u_mt, u_mo, u_st, u_so};
                        end else if (at_le1) begin
                            {mt_n, mo_n, st_n, so_n} = 16'h0000;
                            state_n = DONE;
                        end else begin
                            {mt_n, mo_n, st_n, so_n} = {d_mt, d_mo, d_st, d_so};
                        end
                    end
                    if (pause && state_n == RUN)
                        state_n = PAUSED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mt      <= 4'd0;
            mo      <= 4'd0;
            st      <= 4'd0;
            so      <= 4'd0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mt      <= mt_n;
            mo      <= mo_n;
            st      <= st_n;
            so      <= so_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: seconds-based reference model compared every cycle,
// plus directed scenarios with hand-computed expected counts.
module tb_bcd_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_d = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
    logic [3:0] ld_mt = 4'd0, ld_mo = 4'd0, ld_st = 4'd0, ld_so = 4'd0;
    logic [3:0] mt, mo, st, so;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    bcd_timer dut (
        .clk(clk), .rst(rst), .clk_d(clk_d),
        .start(start), .pause(pause), .clear(clear), .load(load), .dir(dir),
        .ld_mt(ld_mt), .ld_mo(ld_mo), .ld_st(ld_st), .ld_so(ld_so),
        .mt(mt), .mo(mo), .st(st), .so(so),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 run, 2 paused, 3 done; count held as total seconds
    int ms, secs, edge_no;
    int tq[$];
    bit have_prev, prev, tk;

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms = 0; secs = 0; edge_no = 0;
            tq.delete();
            have_prev = 0; prev = 0;
        end else begin
            edge_no++;
            tk = (tq.size() > 0 && tq[0] == edge_no);
            if (tk) void'(tq.pop_front());
            if (have_prev && !prev && clk_d) tq.push_back(edge_no + 2);
            prev = clk_d;
            have_prev = 1;
            if (clear) begin
                ms = 0; secs = 0;
            end else if (ms == 0 || ms == 2) begin
                if (load)
                    secs = (lim(ld_mt, 5) * 10 + lim(ld_mo, 9)) * 60
                         + lim(ld_st, 5) * 10 + lim(ld_so, 9);
                else if (start)
                    ms = (ms == 0 && dir && secs == 0) ? 3 : 1;
            end else if (ms == 1) begin
                if (tk) begin
                    if (!dir) secs = (secs + 1) % 3600;
                    else if (secs <= 1) begin secs = 0; ms = 3; end
                    else secs = secs - 1;
                end
                if (pause && ms == 1) ms = 2;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        r[15:12] = 4'((s / 60) / 10);
        r[11:8]  = 4'((s / 60) % 10);
        r[7:4]   = 4'((s % 60) / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    always @(negedge clk) begin
        checks++;
        if ({mt, mo, st, so} !== to_bcd(secs) || running !== (ms == 1) || done !== (ms == 3)) begin
            errors++;
            $display("FAIL model t=%0t got %h run=%b done=%b exp %h run=%b done=%b",
                     $time, {mt, mo, st, so}, running, done, to_bcd(secs), ms == 1, ms == 3);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse();
        clk_d = 1'b1; cyc(2);
        clk_d = 1'b0; cyc(2);
    endtask

    task automatic setld(input logic [3:0] a, b, c, d);
        ld_mt = a; ld_mo = b; ld_st = c; ld_so = d;
    endtask

    task automatic do_load();
        load = 1'b1; cyc(1); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        chk("reset_cnt", {mt, mo, st, so}, 16'h0000);
        chk("reset_flags", {running, done}, 2'b00);

        setld(4'd0, 4'd1, 4'd0, 4'd5); dir = 1'b1;
        do_load();
        chk("load_0105", {mt, mo, st, so}, 16'h0105);
        do_start();
        chk("run_after_start", running, 1'b1);
        repeat (64) pulse();
        chk("down_0001", {mt, mo, st, so}, 16'h0001);
        pulse();
        chk("down_done_cnt", {mt, mo, st, so}, 16'h0000);
        chk("down_done_flags", {running, done}, 2'b01);
        start = 1'b1; pause = 1'b1; pulse(); start = 1'b0; pause = 1'b0;
        chk("done_sticky", {mt, mo, st, so, running, done}, 18'h00001);

        setld(4'd1, 4'd2, 4'd3, 4'd4);
        clear = 1'b1; load = 1'b1; cyc(1); clear = 1'b0; load = 1'b0;
        chk("clear_over_load", {mt, mo, st, so, running, done}, 18'h00000);

        setld(4'd7, 4'hC, 4'd3, 4'hF);
        do_load();
        chk("load_clamp", {mt, mo, st, so}, 16'h5939);

        do_clear();
        setld(4'd5, 4'd9, 4'd5, 4'd8); dir = 1'b0;
        do_load(); do_start();
        pulse();
        chk("up_5959", {mt, mo, st, so, running}, 17'h0B2B3);
        setld(4'd1, 4'd1, 4'd1, 4'd1);
        do_load();
        chk("load_in_run_ignored", {mt, mo, st, so}, 16'h5959);
        pulse();
        chk("wrap_0000", {mt, mo, st, so, running, done}, 18'h00002);

        do_clear();
        setld(4'd0, 4'd0, 4'd1, 4'd0);
        do_load(); do_start();
        pause = 1'b1; cyc(1); pause = 1'b0;
        chk("paused_flag", running, 1'b0);
        repeat (5) pulse();
        chk("paused_hold", {mt, mo, st, so}, 16'h0010);
        do_start();
        pulse();
        chk("resume_0011", {mt, mo, st, so, running}, 17'h00023);
        pause = 1'b1; cyc(1);
        start = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
        chk("start_pause_resume", running, 1'b1);
        dir = 1'b1; pulse();
        chk("dir_change_0010", {mt, mo, st, so}, 16'h0010);

        do_clear();
        dir = 1'b0; do_start();
        clk_d = 1'b1; cyc(100);
        chk("hold_high_one_step", {mt, mo, st, so}, 16'h0001);
        @(posedge clk); #3 rst = 1'b1;
        #1 chk("async_rst", {mt, mo, st, so, running, done}, 18'h00000);
        cyc(2);
        rst = 1'b0;
        do_start();
        cyc(10);
        chk("no_tick_after_rst", {mt, mo, st, so, running}, 17'h00001);
        clk_d = 1'b0; cyc(2);
        pulse();
        chk("first_tick_after_rst", {mt, mo, st, so}, 16'h0001);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 Parameters: none; all limits are fixed at MM:SS, 00:00 to 59:59.
REQ-002 Reset is asynchronous and active-high; the block has one clock domain, clk.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 clk_d  in  1  divided clock from the upstream divider; sampled as data, never used as a clock.
REQ-006 start  in  1  level; run or resume.
REQ-007 pause  in  1  level; freeze the count.
REQ-008 clear  in  1  level; return to 00:00 and IDLE.
REQ-009 load  in  1  level; load the ld_* digits.
REQ-010 dir  in  1  count direction: 0 = up, 1 = down.
REQ-011 ld_mt, ld_mo, ld_st, ld_so  in  4 each  BCD load digits: minute tens, minute ones, second tens, second ones.
REQ-012 mt, mo, st, so  out  4 each  registered BCD count digits.
REQ-013 running  out  1  high when state is RUN.
REQ-014 done  out  1  high when state is DONE.

Function
REQ-015 clk_d SHALL pass through a 2-flop synchronizer plus a delay flop; tick = sync2 AND NOT sync3.
REQ-016 The count SHALL step on the 3rd clk rising edge after clk_d rises, given setup before edge 1.
REQ-017 Exactly one tick SHALL occur per clk_d rising edge, regardless of how long clk_d stays high.
REQ-018 The FSM SHALL have four states: IDLE, RUN, PAUSED, DONE; it is encoded internally and not exported.
REQ-019 Synchronous command priority SHALL be clear > load > start > pause.
REQ-020 clear SHALL force IDLE and 00:00 from any state on the next edge, ignoring every other input that cycle.
REQ-021 load SHALL act only in IDLE or PAUSED; it loads all four digits and does not change state.
REQ-022 load SHALL be ignored in RUN and DONE.
REQ-023 On load, any ones digit >9 SHALL be loaded as 9; any tens digit >5 SHALL be loaded as 5.
REQ-024 IDLE: start goes to RUN; in down mode with count 00:00, start goes directly to DONE.
REQ-025 RUN: on tick the count SHALL step by one second in the direction given by dir sampled that cycle.
REQ-026 Carry/borrow SHALL ripple so -> st -> mo -> mt, with so 0..9, st 0..5, mo 0..9, mt 0..5.
REQ-027 Up mode at 59:59 plus tick SHALL wrap to 00:00; the FSM remains in RUN and done stays 0.
REQ-028 Down mode at 00:01 plus tick SHALL give 00:00 and enter DONE on the same edge.
REQ-029 RUN: pause SHALL go to PAUSED; a tick in the same cycle is still applied on that edge.
REQ-030 RUN: start SHALL have no effect.
REQ-031 RUN: a change of dir takes effect at the next tick; no step occurs without a tick.
REQ-032 PAUSED: ticks SHALL be ignored; start returns to RUN.
REQ-033 PAUSED: start and pause together SHALL resume, because start has higher priority.
REQ-034 DONE: the count SHALL hold 00:00 and ticks, start and pause are ignored; only clear or rst leaves DONE.
REQ-035 running and done SHALL be registered and valid in the same cycle as the state they reflect.

Reset
REQ-036 On rst high, asynchronously: state = IDLE; mt = mo = st = so = 0; running = 0; done = 0; all three synchronizer flops = 0.
REQ-037 After rst is released, the first tick SHALL require a new clk_d rising edge, even if clk_d is already high.
REQ-038 rst asserted mid-RUN SHALL discard the count and any pending tick.

Verification
REQ-039 Load 01:05 with dir = 1, then start and apply 65 clk_d pulses -> count reaches 00:00 and done = 1 on the 65th step edge; running = 0.
REQ-040 Load 59:58 with dir = 0, then start and apply 2 pulses -> 59:59, then 00:00; running stays 1 and done stays 0.
REQ-041 In RUN at 00:10, pause, apply 5 pulses, then start and apply 1 pulse -> count holds 00:10 while paused, then shows 00:11.
REQ-042 In DONE, assert clear and load in the same cycle -> IDLE, 00:00 and done = 0; the load is ignored.
REQ-043 In IDLE, load ld_mt = 7, ld_mo = 4'hC, ld_st = 3, ld_so = 4'hF -> count reads 59:39.
REQ-044 Hold clk_d high for 100 clk cycles in RUN -> exactly one step; then assert rst mid-count -> all outputs 0 and IDLE immediately, without waiting for a clk edge.
